// File: rtl/adc_serial_pkg.sv
// Shared types and constants for the serial ADC frame reader.
package adc_serial_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t CS_SETUP = 2'd1;
    localparam state_t SHIFT    = 2'd2;
    localparam state_t CS_HOLD  = 2'd3;

    // Chip-select quiet time after a frame, in SCLK half-periods.
    localparam int HOLD_HALVES = 4;

    // Bits needed for a counter that must reach max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_ce_div.sv
// Clock-enable divider: count runs 0..CE_DIV-1 while enabled, ce marks the last count.
module clk_ce_div
    import adc_serial_pkg::*;
#(
    parameter int CE_DIV = 12,
    localparam int CW = cnt_width(CE_DIV - 1)
) (
    input  logic          clk_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    output logic          ce,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);

    // Free-running modulo counter; clear wins over enable.
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign ce = enable && !clear && (count == LAST);

endmodule

// File: rtl/adc_serial_reader.sv
// Frame reader for a CS-framed, MSB-first serial ADC with leading zeros.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | cs_n high, sclk high, waiting for start
// CS_SETUP | cs_n low, one half-period with sclk still high
// SHIFT    | sclk toggles on each ce; data sampled on the rising toggle
// CS_HOLD  | cs_n high, sclk high for HOLD_HALVES half-periods
module adc_serial_reader
    import adc_serial_pkg::*;
#(
    parameter int CE_DIV     = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_ZEROS = 4,
    parameter int DATA_BITS  = 12
) (
    input  logic                 clk_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 overrun
);

    localparam int DW = cnt_width(CE_DIV - 1);
    localparam int EW = cnt_width(FRAME_BITS);
    localparam int HW = cnt_width(HOLD_HALVES - 1);

    localparam logic [EW-1:0] LAST_EDGE = EW'(FRAME_BITS - 1);

    state_t                state;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS-1:0] shift_nxt;
    logic [EW-1:0]         edges;
    logic [HW-1:0]         hold_cnt;
    logic                  ce;
    logic [DW-1:0]         div_count;
    logic                  unused_bits;

    // The divider is held at zero in IDLE so CS_SETUP always starts a full half-period.
    clk_ce_div #(
        .CE_DIV (CE_DIV)
    ) u_div (
        .clk_clk (clk_clk),
        .reset   (reset),
        .enable  (state != IDLE),
        .clear   (state == IDLE),
        .ce      (ce),
        .count   (div_count)
    );

    // The final rising edge's bit must be part of the captured word, so capture
    // from the next-shift value rather than the register.
    assign shift_nxt = {shift[FRAME_BITS-2:0], sdata};
    assign busy      = (state != IDLE);

    // The divider phase and the shift MSB / pad bits are not needed here.
    assign unused_bits = ^{div_count, shift[FRAME_BITS-1], shift_nxt};

    // Frame sequencing, shift capture and sticky overrun.
    always_ff @(posedge clk_clk) begin
        if (reset) begin
            state        <= IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b1;
            shift        <= '0;
            edges        <= '0;
            hold_cnt     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b1;
                    if (start) begin
                        state <= CS_SETUP;
                        cs_n  <= 1'b0;
                        edges <= '0;
                    end
                end
                CS_SETUP: begin
                    if (ce) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ce) begin
                        sclk <= ~sclk;
                        if (!sclk) begin
                            shift <= shift_nxt;
                            edges <= edges + 1'b1;
                            if (edges == LAST_EDGE) begin
                                state        <= CS_HOLD;
                                cs_n         <= 1'b1;
                                sample       <= shift_nxt[FRAME_BITS-1-LEAD_ZEROS -: DATA_BITS];
                                sample_valid <= 1'b1;
                                frame_err    <= |shift_nxt[FRAME_BITS-1 -: LEAD_ZEROS];
                                hold_cnt     <= HW'(HOLD_HALVES - 1);
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (ce) begin
                        if (hold_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: default instance plus a CE_DIV=2 instance,
// checked every cycle against a timeline model of the frame.
module tb_adc_serial_reader;

    localparam int F = 16;

    logic        clk_clk = 1'b0;
    logic        reset, start, start2, sdata, sdata2;
    logic        cs_n, sclk, sample_valid, frame_err, busy, overrun;
    logic        cs_n2, sclk2, sample_valid2, frame_err2, busy2, overrun2;
    logic [11:0] sample, sample2;

    always #5 clk_clk = ~clk_clk;

    adc_serial_reader dut (
        .clk_clk(clk_clk), .reset(reset), .start(start), .sdata(sdata),
        .cs_n(cs_n), .sclk(sclk), .sample(sample), .sample_valid(sample_valid),
        .frame_err(frame_err), .busy(busy), .overrun(overrun)
    );

    adc_serial_reader #(.CE_DIV(2)) dut2 (
        .clk_clk(clk_clk), .reset(reset), .start(start2), .sdata(sdata2),
        .cs_n(cs_n2), .sclk(sclk2), .sample(sample2), .sample_valid(sample_valid2),
        .frame_err(frame_err2), .busy(busy2), .overrun(overrun2)
    );

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // ADC pin model: word latched when cs_n falls, bit k presented after k-th sclk fall
    logic [15:0] word[2]  = '{16'h0, 16'h0};
    logic [15:0] cur[2]   = '{16'h0, 16'h0};
    int          falls[2] = '{0, 0};
    logic        a_psk[2] = '{1'b1, 1'b1};
    logic        a_pcs[2] = '{1'b1, 1'b1};

    // Timeline model state
    bit          m_act[2]    = '{1'b0, 1'b0};
    int          m_t0[2]     = '{0, 0};
    logic [15:0] m_word[2]   = '{16'h0, 16'h0};
    logic [11:0] m_sample[2] = '{12'h0, 12'h0};
    logic        m_err[2]    = '{1'b0, 1'b0};
    logic        m_ovr[2]    = '{1'b0, 1'b0};

    // Observed-output monitors
    int   vcnt[2]   = '{0, 0};
    int   vfirst[2] = '{-1, -1};
    int   vlast[2]  = '{-1, -1};
    int   lowcnt[2] = '{0, 0};
    int   rises[2]  = '{0, 0};
    logic o_psk[2]  = '{1'b1, 1'b1};
    logic o_pcs[2]  = '{1'b1, 1'b1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic adc_step(input int i, input logic cs, input logic sk, output logic b);
        int idx;
        if (cs) begin
            falls[i] = 0;
        end else begin
            if (a_pcs[i]) cur[i] = word[i];
            if (a_psk[i] && !sk) falls[i]++;
        end
        a_pcs[i] = cs;
        a_psk[i] = sk;
        idx = (falls[i] == 0) ? 15 : 16 - falls[i];
        b = cur[i][idx];
    endtask

    always @(posedge clk_clk) begin
        #2;
        adc_step(0, cs_n, sclk, sdata);
        adc_step(1, cs_n2, sclk2, sdata2);
    end

    task automatic model_step(input int i, input int ce, input logic rst, input logic st,
                              input logic cs, input logic sk, input logic sv, input logic fe,
                              input logic bz, input logic ov, input logic [11:0] smp);
        int d, h, tv, ti;
        logic e_cs, e_sk, e_sv, e_bz;
        tv = 1 + ce * (2 * F + 1);
        ti = tv + 4 * ce;
        e_cs = 1'b1; e_sk = 1'b1; e_sv = 1'b0; e_bz = 1'b0;
        if (m_act[i]) begin
            d = cyc - m_t0[i];
            if (d >= 1 && d < tv) begin
                e_cs = 1'b0;
                h = (d - 1) / ce;
                e_sk = (h < 2) || (h % 2 == 1);
            end
            if (d >= 1 && d < ti) e_bz = 1'b1;
            if (d == tv) begin
                e_sv = 1'b1;
                m_sample[i] = m_word[i][11:0];
                m_err[i]    = (m_word[i][15:12] != 4'h0);
            end
            if (d >= ti) m_act[i] = 1'b0;
        end
        chk($sformatf("cs_n%0d", i), cs, e_cs);
        chk($sformatf("sclk%0d", i), sk, e_sk);
        chk($sformatf("sample_valid%0d", i), sv, e_sv);
        chk($sformatf("busy%0d", i), bz, e_bz);
        chk($sformatf("overrun%0d", i), ov, m_ovr[i]);
        chk($sformatf("sample%0d", i), smp, m_sample[i]);
        if (e_sv) chk($sformatf("frame_err%0d", i), fe, m_err[i]);

        if (sv) begin
            if (vcnt[i] == 0) vfirst[i] = cyc;
            vlast[i] = cyc;
            vcnt[i]++;
        end
        if (!cs) lowcnt[i]++;
        if (sk && !o_psk[i] && !o_pcs[i]) rises[i]++;
        o_psk[i] = sk;
        o_pcs[i] = cs;

        if (rst) begin
            m_act[i] = 1'b0; m_sample[i] = 12'h0; m_err[i] = 1'b0; m_ovr[i] = 1'b0;
        end else if (st) begin
            if (e_bz) m_ovr[i] = 1'b1;
            else begin
                m_act[i] = 1'b1; m_t0[i] = cyc; m_word[i] = word[i];
            end
        end
    endtask

    always @(negedge clk_clk) begin
        if (chk_en) begin
            model_step(0, 12, reset, start, cs_n, sclk, sample_valid, frame_err, busy, overrun, sample);
            model_step(1, 2, reset, start2, cs_n2, sclk2, sample_valid2, frame_err2, busy2, overrun2, sample2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic clr(input int i);
        vcnt[i] = 0; vfirst[i] = -1; vlast[i] = -1; lowcnt[i] = 0; rises[i] = 0;
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        finish_run();
    end

    initial begin
        int t, t2, r;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        tick(2);
        chk_en = 1'b1;
        tick(1);
        reset = 1'b0;

        // Frame 0x0ABC with literal timing
        word[0] = 16'h0ABC; clr(0);
        start = 1'b1; t = cyc; tick(1); start = 1'b0;
        to_cycle(t + 398);
        chk("t1_valid_cycle", vfirst[0] - t, 397);
        chk("t1_sample", sample, 12'hABC);
        chk("t1_frame_err", frame_err, 1'b0);
        chk("t1_cs_low_cycles", lowcnt[0], 396);
        chk("t1_sclk_rises", rises[0], 16);
        chk("t1_valid_count", vcnt[0], 1);
        to_cycle(t + 444);
        chk("t1_busy_444", busy, 1'b1);
        tick(1);
        chk("t1_busy_445", busy, 1'b0);

        // Leading-zero violation, started on the first idle cycle
        word[0] = 16'h8123; clr(0);
        start = 1'b1; t = cyc; tick(1); start = 1'b0;
        to_cycle(t + 398);
        chk("t2_valid_cycle", vfirst[0] - t, 397);
        chk("t2_sample", sample, 12'h123);
        chk("t2_frame_err", frame_err, 1'b1);
        to_cycle(t + 445);

        // Starts during a frame: dropped, overrun set; start at 445 accepted
        word[0] = 16'h0F0F; clr(0);
        start = 1'b1; t = cyc; tick(1); start = 1'b0;
        to_cycle(t + 200);
        start = 1'b1; tick(1); start = 1'b0;
        chk("t3_overrun_set", overrun, 1'b1);
        to_cycle(t + 444);
        word[0] = 16'h0777;
        start = 1'b1; tick(1); tick(1); start = 1'b0;
        chk("t3_one_valid", vcnt[0], 1);
        chk("t3_first_sample", sample, 12'hF0F);
        t2 = t + 445;
        to_cycle(t2 + 398);
        chk("t3_second_valid_cycle", vlast[0] - t2, 397);
        chk("t3_second_sample", sample, 12'h777);
        chk("t3_overrun_sticky", overrun, 1'b1);
        to_cycle(t2 + 445);

        // Reset mid-SHIFT
        word[0] = 16'h0FFF; clr(0);
        start = 1'b1; t = cyc; tick(1); start = 1'b0;
        to_cycle(t + 150);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("t4_cs_n_after_reset", cs_n, 1'b1);
        chk("t4_sclk_after_reset", sclk, 1'b1);
        chk("t4_overrun_cleared", overrun, 1'b0);
        to_cycle(t + 500);
        chk("t4_no_valid", vcnt[0], 0);
        word[0] = 16'h0555; clr(0);
        start = 1'b1; t = cyc; tick(1); start = 1'b0;
        to_cycle(t + 398);
        chk("t4_sample", sample, 12'h555);
        chk("t4_valid_cycle", vfirst[0] - t, 397);
        to_cycle(t + 445);

        // CE_DIV=2, start held high across two frames
        word[1] = 16'h0FFF; clr(1);
        start2 = 1'b1; t = cyc; tick(2);
        word[1] = 16'h0000;
        to_cycle(t + 68);
        chk("t5_first_sample", sample2, 12'hFFF);
        chk("t5_first_valid_cycle", vfirst[1] - t, 67);
        to_cycle(t + 76);
        start2 = 1'b0;
        to_cycle(t + 151);
        chk("t5_valid_count", vcnt[1], 2);
        chk("t5_second_valid_cycle", vlast[1] - t, 142);
        chk("t5_second_sample", sample2, 12'h000);
        chk("t5_cs_low_cycles", lowcnt[1], 132);
        chk("t5_sclk_rises", rises[1], 32);
        chk("t5_overrun", overrun2, 1'b1);

        // start held through reset release
        word[0] = 16'h0321; clr(0);
        reset = 1'b1; start = 1'b1;
        tick(2);
        reset = 1'b0; r = cyc;
        tick(1);
        start = 1'b0;
        chk("t6_cs_n_low_after_release", cs_n, 1'b0);
        to_cycle(r + 398);
        chk("t6_valid_cycle", vfirst[0] - r, 397);
        chk("t6_sample", sample, 12'h321);
        chk("t6_overrun_clear", overrun, 1'b0);
        to_cycle(r + 446);

        finish_run();
    end

endmodule
